// File: rtl/btn_arb_pkg.sv
// Shared types and constants for the tick-sampled button event arbiter.
package btn_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int DEF_TICK_DIV     = 100000;
  localparam int DEF_REPEAT_TICKS = 250;

  // Width of a button index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_edge_sampler.sv
// One button channel: two-stage tick sampler, rising-edge pulse and, with
// BTN_AUTO_REPEAT_EN defined, a hold-to-repeat tick counter.
module btn_edge_sampler
  import btn_arb_pkg::*;
`ifdef BTN_AUTO_REPEAT_EN
  #(parameter int REPEAT_TICKS = DEF_REPEAT_TICKS)
`endif
(
  input  logic clk_in,
  input  logic reset_in,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic s1, s2, press;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (tick) begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  assign level = s2;
  assign press = tick & s1 & ~s2;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  logic [RW-1:0] rcnt;
  logic          rpt;

  // Fires on the tick that would bring the held count up to REPEAT_TICKS.
  assign rpt = tick & s2 & (rcnt == RW'(REPEAT_TICKS - 1));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rcnt <= '0;
    end else if (press || !s2 || rpt) begin
      rcnt <= '0;
    end else if (tick) begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign rise = press | rpt;
`else
  assign rise = press;
`endif

endmodule

// File: rtl/button_event_arbiter.sv
// Tick generator, per-button samplers, pending bitmap with drop counter and a
// round-robin valid/ready arbiter. Optional auto-repeat: BTN_AUTO_REPEAT_EN.
module button_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter  int N_BTN        = 5,
  parameter  int TICK_DIV     = DEF_TICK_DIV,
  parameter  int DROP_W       = 8,
  parameter  int REPEAT_TICKS = DEF_REPEAT_TICKS,
  localparam int ID_W         = id_width(N_BTN)
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [N_BTN-1:0]  btn_in,
  output logic              event_valid,
  output logic [ID_W-1:0]   event_id,
  input  logic              event_ready,
  output logic [N_BTN-1:0]  btn_level,
  output logic [N_BTN-1:0]  pending,
  output logic [DROP_W-1:0] drop_count
);

  localparam int TW = $clog2(TICK_DIV);

  if (N_BTN < 2 || N_BTN > 16 || TICK_DIV < 2 || DROP_W < 1 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("button_event_arbiter: illegal parameter set");
  end

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [N_BTN-1:0] rise, clr, drops;
  logic             accept;
  logic [ID_W-1:0]  rr_ptr, sel, hi_sel, lo_sel;
  logic             hi_found;
  arb_state_t       state;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (reset_in || tick) tick_cnt <= '0;
    else                  tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_edge_sampler
`ifdef BTN_AUTO_REPEAT_EN
      #(.REPEAT_TICKS(REPEAT_TICKS))
`endif
    u_smp (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .tick     (tick),
      .btn      (btn_in[g]),
      .level    (btn_level[g]),
      .rise     (rise[g])
    );
  end

  assign accept = event_valid & event_ready;
  assign clr    = {{(N_BTN-1){1'b0}}, accept} << event_id;
  // A fresh edge on the channel being accepted re-arms it rather than dropping.
  assign drops  = rise & pending & ~clr;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pending    <= '0;
      drop_count <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (|drops && drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + 1'b1;
    end
  end

  // Round-robin pick: lowest set bit at or above rr_ptr, else lowest set bit.
  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_sel = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_sel   = ID_W'(i);
        end
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state       <= IDLE;
      event_valid <= 1'b0;
      event_id    <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            event_id    <= sel;
            event_valid <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (event_ready) begin
            event_valid <= 1'b0;
            state       <= IDLE;
            rr_ptr      <= (event_id == ID_W'(N_BTN - 1)) ? '0 : event_id + 1'b1;
          end
        end
        default: begin
          event_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench: expected event ids are queued as buttons are driven and
// popped at each accepted handshake; state checks are immediate assertions.
module tb_button_event_arbiter;

  localparam int N  = 5;
  localparam int TD = 4;
  localparam int DW = 2;
  localparam int RT = 3;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic [N-1:0]  btn_in;
  logic          event_valid;
  logic [2:0]    event_id;
  logic          event_ready;
  logic [N-1:0]  btn_level;
  logic [N-1:0]  pending;
  logic [DW-1:0] drop_count;

  int vectors = 0;
  int errs    = 0;
  int q[$];

  button_event_arbiter #(.N_BTN(N), .TICK_DIV(TD), .DROP_W(DW), .REPEAT_TICKS(RT)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .btn_in      (btn_in),
    .event_valid (event_valid),
    .event_id    (event_id),
    .event_ready (event_ready),
    .btn_level   (btn_level),
    .pending     (pending),
    .drop_count  (drop_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!event_valid && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    chk(tag, 32'(k < 100), 32'd1);
  endtask

  // Handshake monitor: event accepted at the next rising edge.
  always @(negedge clk_in) begin
    if (!reset_in && event_valid && event_ready) begin
      if (q.size() == 0) begin
        vectors++;
        errs++;
        $error("FAIL unexpected_event: got id %0d expected none", event_id);
      end else begin
        chk("event_id_order", 32'(event_id), 32'(q.pop_front()));
      end
    end
  end

  initial begin
    int k;
    // Reset with all buttons held.
    reset_in = 1'b1; btn_in = 5'h1F; event_ready = 1'b0;
    cyc(3);
    @(negedge clk_in);
    chk("rst_valid",   32'(event_valid), 32'd0);
    chk("rst_id",      32'(event_id),    32'd0);
    chk("rst_level",   32'(btn_level),   32'd0);
    chk("rst_pending", 32'(pending),     32'd0);
    chk("rst_drop",    32'(drop_count),  32'd0);

    // Single press: valid exactly one cycle after pending rises.
    cyc(1);
    reset_in = 1'b0; btn_in = 5'b00100;
    k = 0;
    while (!pending[2] && k < 40) begin
      @(negedge clk_in);
      k++;
    end
    chk("pend2_timeout", 32'(k < 40), 32'd1);
    chk("pend2_valid_lo", 32'(event_valid), 32'd0);
    chk("pend2_level",    32'(btn_level),   32'b00100);
    @(negedge clk_in);
    chk("pend2_valid_hi", 32'(event_valid), 32'd1);
    chk("pend2_id",       32'(event_id),    32'd2);
    q.push_back(2);
    cyc(1);
    event_ready = 1'b1;
    cyc(3);
    @(negedge clk_in);
    chk("pend2_cleared", 32'(pending), 32'd0);
    cyc(1);
    btn_in = '0;

    // Simultaneous press from rr_ptr=0, then a second round.
    reset_in = 1'b1;
    cyc(2);
    reset_in = 1'b0; btn_in = 5'b10011;
    q.push_back(0); q.push_back(1); q.push_back(4);
    cyc(40);
    chk("rr_round1_drained", 32'(q.size()), 32'd0);
    chk("rr_round1_pending", 32'(pending),  32'd0);
    btn_in = '0;
    cyc(12);
    btn_in = 5'b10001;
    q.push_back(0); q.push_back(4);
    cyc(40);
    chk("rr_round2_drained", 32'(q.size()), 32'd0);
    btn_in = '0;
    cyc(12);

    // Offer holds while stalled; new press only sets pending.
    event_ready = 1'b0;
    btn_in = 5'b01000;
    wait_valid("offer3_timeout");
    chk("offer3_id", 32'(event_id), 32'd3);
    cyc(1);
    btn_in = 5'b01010;
    cyc(16);
    @(negedge clk_in);
    chk("stall_valid",   32'(event_valid), 32'd1);
    chk("stall_id",      32'(event_id),    32'd3);
    chk("stall_pending", 32'(pending),     32'b01010);
    q.push_back(3); q.push_back(1);
    cyc(1);
    event_ready = 1'b1;
    btn_in = '0;
    cyc(12);
    chk("stall_drained", 32'(q.size()), 32'd0);

    // Drops while pending[2] is held unaccepted; 2-bit counter saturates.
    event_ready = 1'b0;
    btn_in = 5'b00100; cyc(8);
    btn_in = '0;       cyc(8);
    for (int r = 0; r < 2; r++) begin
      btn_in = 5'b00100; cyc(8);
      btn_in = '0;       cyc(8);
    end
    @(negedge clk_in);
    chk("drop_two",     32'(drop_count),  32'd2);
    chk("drop_valid",   32'(event_valid), 32'd1);
    chk("drop_id",      32'(event_id),    32'd2);
    cyc(1);
    for (int r = 0; r < 3; r++) begin
      btn_in = 5'b00100; cyc(8);
      btn_in = '0;       cyc(8);
    end
    @(negedge clk_in);
    chk("drop_saturated", 32'(drop_count), 32'd3);
    q.push_back(2);
    cyc(1);
    event_ready = 1'b1;
    cyc(6);
    chk("drop_pending_clear", 32'(pending), 32'd0);

    // Reset during OFFER: offer and pending discarded, rr_ptr back to 0.
    event_ready = 1'b0;
    btn_in = 5'b00001;
    wait_valid("offer0_timeout");
    chk("offer0_id", 32'(event_id), 32'd0);
    cyc(1);
    reset_in = 1'b1; btn_in = '0;
    cyc(1);
    reset_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_valid",   32'(event_valid), 32'd0);
    chk("midrst_pending", 32'(pending),     32'd0);
    chk("midrst_drop",    32'(drop_count),  32'd0);
    cyc(1);
    btn_in = 5'b10010; event_ready = 1'b1;
    q.push_back(1); q.push_back(4);
    cyc(40);
    chk("midrst_rr_drained", 32'(q.size()), 32'd0);
    btn_in = '0;
    cyc(12);

    // Long hold: one event, or press plus a repeat every RT ticks.
    q.push_back(0);
`ifdef BTN_AUTO_REPEAT_EN
    q.push_back(0); q.push_back(0); q.push_back(0);
`endif
    btn_in = 5'b00001;
    cyc(44);
    btn_in = '0;
    cyc(20);
    chk("hold_pending", 32'(pending), 32'd0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
